// File: rtl/qerv_mem_arbiter.sv
// qerv_mem_arbiter: shares one Wishbone-style memory port between the fetch
// (ibus) and data (dbus) requesters of a bit-serial core.
//   - Round-robin arbitration on simultaneous requests, one-cycle grant latency.
//   - Acks and read data pass straight through from memory with no added latency.
//   - Optional watchdog, enabled by defining QERV_ARB_WATCHDOG_EN: a transaction
//     the memory never acks is completed with zero data after TIMEOUT_CYCLES
//     cycles, and the sticky o_timeout flag is raised.
//   - RESET_STRATEGY "NONE" leaves last_grant and the watchdog counter unreset;
//     only the FSM state and the timeout flag are reset.
module qerv_mem_arbiter #(
  parameter RESET_STRATEGY = "MINI",
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // fetch requester
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  // data requester
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  // shared memory port
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  // sticky watchdog flag
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant_dbus;  // 1 when the most recent grant went to dbus

  logic   gnt_i_active;     // ibus owns the port and is still requesting
  logic   gnt_d_active;     // dbus owns the port and is still requesting
  logic   port_busy;        // some granted requester is still requesting
  logic   wd_fire;          // watchdog completes the transaction this cycle
  logic   done;             // granted transaction completes this cycle

  assign gnt_i_active = (state == GNT_I) && i_ibus_cyc;
  assign gnt_d_active = (state == GNT_D) && i_dbus_cyc;
  assign port_busy    = gnt_i_active || gnt_d_active;

  // A watchdog completion replaces the memory cycle, so the port drops at once.
  assign o_wb_cyc = !i_rst && port_busy && !wd_fire;
  assign done     = !i_rst && (i_wb_ack || wd_fire);

  assign o_ibus_ack = gnt_i_active && done;
  assign o_dbus_ack = gnt_d_active && done;

  assign o_ibus_rdt = wd_fire ? 32'h0 : i_wb_rdt;
  assign o_dbus_rdt = wd_fire ? 32'h0 : i_wb_rdt;

  // Fetches are always full-word reads; every other state presents the dbus.
  assign o_wb_adr = (state == GNT_I) ? i_ibus_adr : i_dbus_adr;
  assign o_wb_sel = (state == GNT_I) ? 4'hF       : i_dbus_sel;
  assign o_wb_we  = (state == GNT_I) ? 1'b0       : i_dbus_we;
  assign o_wb_dat = i_dbus_dat;

  // Arbitration FSM: grant from IDLE, return to IDLE on ack, abort or timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      if (RESET_STRATEGY != "NONE") begin
        last_grant_dbus <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_ibus_cyc && i_dbus_cyc) begin
            if (last_grant_dbus) begin
              state           <= GNT_I;
              last_grant_dbus <= 1'b0;
            end else begin
              state           <= GNT_D;
              last_grant_dbus <= 1'b1;
            end
          end else if (i_ibus_cyc) begin
            state           <= GNT_I;
            last_grant_dbus <= 1'b0;
          end else if (i_dbus_cyc) begin
            state           <= GNT_D;
            last_grant_dbus <= 1'b1;
          end
        end
        GNT_I: begin
          if (!i_ibus_cyc || o_ibus_ack) begin
            state <= IDLE;
          end
        end
        GNT_D: begin
          if (!i_dbus_cyc || o_dbus_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QERV_ARB_WATCHDOG_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wd_count;
  logic       timeout_reg;

  // A real ack in the limit cycle takes priority over the watchdog.
  assign wd_fire   = port_busy && (wd_count == TIMEOUT_LIMIT) && !i_wb_ack;
  assign o_timeout = timeout_reg;

  // Watchdog: count unacked busy cycles of the current grant; flag is sticky.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_reg <= 1'b0;
      if (RESET_STRATEGY != "NONE") begin
        wd_count <= 8'd0;
      end
    end else begin
      if (wd_fire) begin
        timeout_reg <= 1'b1;
      end
      // Every grant is issued from IDLE, so clearing here starts each grant at 0.
      if (state == IDLE) begin
        wd_count <= 8'd0;
      end else if (o_wb_cyc && !i_wb_ack) begin
        wd_count <= wd_count + 8'd1;
      end
    end
  end
`else
  assign wd_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_qerv_mem_arbiter.sv
// tb_qerv_mem_arbiter: directed scenarios with literal expectations, plus a
// transaction-level model of the arbiter (owner / previous winner / busy time)
// that every cycle predicts all outputs and is compared on the falling edge.
module tb_qerv_mem_arbiter;

  localparam int TMO = 4;
`ifdef QERV_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_ibus_adr = '0;
  logic        i_ibus_cyc = 1'b0;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr = '0;
  logic [31:0] i_dbus_dat = '0;
  logic [3:0]  i_dbus_sel = '0;
  logic        i_dbus_we  = 1'b0;
  logic        i_dbus_cyc = 1'b0;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt = '0;
  logic        i_wb_ack = 1'b0;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  qerv_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
    .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
    .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
    .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
    .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  int m_owner = 0;  // 0 nobody, 1 ibus, 2 dbus
  int m_prev  = 1;  // requester that won the most recent grant
  int m_busy  = 0;  // cycles the current owner has waited without an ack
  bit m_to    = 1'b0;
  bit armed   = 1'b0;

  function automatic void model_eval(output bit served, output bit expire, output bit done);
    served = (m_owner == 1 && i_ibus_cyc) || (m_owner == 2 && i_dbus_cyc);
    expire = WD && served && (m_busy >= TMO) && !i_wb_ack;
    done   = !i_rst && served && (i_wb_ack || expire);
  endfunction

  always @(posedge i_clk) begin
    bit served, expire, done;
    model_eval(served, expire, done);
    if (i_rst) begin
      m_owner = 0; m_prev = 1; m_busy = 0; m_to = 1'b0;
    end else if (m_owner == 0) begin
      m_busy = 0;
      if (i_ibus_cyc && i_dbus_cyc) m_owner = (m_prev == 1) ? 2 : 1;
      else if (i_ibus_cyc)          m_owner = 1;
      else if (i_dbus_cyc)          m_owner = 2;
      if (m_owner != 0) m_prev = m_owner;
    end else begin
      if (expire) m_to = 1'b1;
      if (!served || done) m_owner = 0;
      else if (!i_wb_ack)  m_busy++;
    end
    armed = 1'b1;
  end

  always @(negedge i_clk) begin
    bit served, expire, done;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic        e_we;
    if (armed) begin
      model_eval(served, expire, done);
      e_adr = (m_owner == 1) ? i_ibus_adr : i_dbus_adr;
      e_sel = (m_owner == 1) ? 4'hF : i_dbus_sel;
      e_we  = (m_owner == 1) ? 1'b0 : i_dbus_we;
      chk1("m_wb_cyc",   o_wb_cyc,   !i_rst && served && !expire);
      chk1("m_ibus_ack", o_ibus_ack, done && m_owner == 1);
      chk1("m_dbus_ack", o_dbus_ack, done && m_owner == 2);
      chk ("m_wb_adr",   o_wb_adr,   e_adr);
      chk ("m_wb_sel",   {28'h0, o_wb_sel}, {28'h0, e_sel});
      chk1("m_wb_we",    o_wb_we,    e_we);
      chk ("m_wb_dat",   o_wb_dat,   i_dbus_dat);
      chk1("m_timeout",  o_timeout,  m_to);
      if (done) begin
        chk("m_ibus_rdt", o_ibus_rdt, expire ? 32'h0 : i_wb_rdt);
        chk("m_dbus_rdt", o_dbus_rdt, expire ? 32'h0 : i_wb_rdt);
      end
    end
  end

  // Both requesters raise cyc together; exp_d says dbus should win.
  task automatic conflict(input bit exp_d, input bit serve_other);
    i_ibus_adr = 32'h300; i_dbus_adr = 32'h200; i_dbus_we = 1'b0;
    i_dbus_sel = 4'b0101; i_dbus_dat = 32'h12345678;
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    step(); #2;
    chk("arb_first_adr", o_wb_adr, exp_d ? 32'h200 : 32'h300);
    chk("arb_first_sel", {28'h0, o_wb_sel}, exp_d ? 32'h5 : 32'hF);
    i_wb_ack = 1'b1; i_wb_rdt = 32'h0BADF00D; #1;
    chk1("arb_first_ack", exp_d ? o_dbus_ack : o_ibus_ack, 1'b1);
    chk1("arb_other_noack", exp_d ? o_ibus_ack : o_dbus_ack, 1'b0);
    step(); i_wb_ack = 1'b0;
    if (exp_d) i_dbus_cyc = 1'b0; else i_ibus_cyc = 1'b0;
    if (!serve_other) begin i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; end
    #2 chk1("arb_gap_cyc", o_wb_cyc, 1'b0);
    if (serve_other) begin
      step(); #2;
      chk("arb_second_adr", o_wb_adr, exp_d ? 32'h300 : 32'h200);
      i_wb_ack = 1'b1; #1;
      chk1("arb_second_ack", exp_d ? o_ibus_ack : o_dbus_ack, 1'b1);
      step(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
    end
  endtask

  initial begin
    // reset
    step(); step(); i_rst = 1'b0;
    #2 chk1("reset_cyc", o_wb_cyc, 1'b0);
    chk1("reset_timeout", o_timeout, 1'b0);

    // single fetch, memory acks two cycles after o_wb_cyc
    i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
    #1 chk1("fetch_req_cycle_cyc", o_wb_cyc, 1'b0);
    step(); #2 chk1("fetch_cyc_lat1", o_wb_cyc, 1'b1);
    chk("fetch_adr", o_wb_adr, 32'h100);
    step(); #2 chk1("fetch_no_early_ack", o_ibus_ack, 1'b0);
    step(); i_wb_ack = 1'b1; i_wb_rdt = 32'hA5A5A5A5;
    #2 chk1("fetch_ack", o_ibus_ack, 1'b1);
    chk("fetch_rdt", o_ibus_rdt, 32'hA5A5A5A5);
    step(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
    #2 chk1("fetch_back_idle", o_wb_cyc, 1'b0);

    // arbitration sequence: D then I, D, I then D, I
    i_rst = 1'b1; step(); i_rst = 1'b0;
    conflict(1'b1, 1'b1);
    conflict(1'b1, 1'b0);
    conflict(1'b0, 1'b1);
    conflict(1'b0, 1'b0);

    // dbus write
    i_dbus_adr = 32'h400; i_dbus_dat = 32'hDEADBEEF; i_dbus_sel = 4'b0011;
    i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    step(); #2;
    chk1("write_we", o_wb_we, 1'b1);
    chk("write_sel", {28'h0, o_wb_sel}, 32'h3);
    chk("write_dat", o_wb_dat, 32'hDEADBEEF);
    step(); i_wb_ack = 1'b1; #1;
    chk1("write_dack", o_dbus_ack, 1'b1);
    chk1("write_no_iack", o_ibus_ack, 1'b0);
    step(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0;

    // stray ack while idle, then fetch aborted before its ack
    i_wb_ack = 1'b1;
    #2 chk1("idle_ack_i", o_ibus_ack, 1'b0);
    chk1("idle_ack_d", o_dbus_ack, 1'b0);
    step(); i_wb_ack = 1'b0; i_ibus_adr = 32'h180; i_ibus_cyc = 1'b1;
    step(); #2 chk1("abort_pre_cyc", o_wb_cyc, 1'b1);
    step(); i_ibus_cyc = 1'b0; i_wb_ack = 1'b1;
    #2 chk1("abort_cyc", o_wb_cyc, 1'b0);
    chk1("abort_noack", o_ibus_ack, 1'b0);
    step(); i_wb_ack = 1'b0;
    #2 chk1("abort_idle", o_wb_cyc, 1'b0);

    // reset in the middle of a dbus transaction
    i_dbus_adr = 32'h500; i_dbus_cyc = 1'b1;
    step(); #2 chk1("rst_pre_cyc", o_wb_cyc, 1'b1);
    i_rst = 1'b1; i_wb_ack = 1'b1; #1;
    chk1("rst_cyc", o_wb_cyc, 1'b0);
    chk1("rst_dack", o_dbus_ack, 1'b0);
    step(); i_rst = 1'b0; i_wb_ack = 1'b0;
    #2 chk1("rst_idle", o_wb_cyc, 1'b0);
    step(); #2 chk1("rst_regrant", o_wb_cyc, 1'b1);
    i_wb_ack = 1'b1; #1 chk1("rst_regrant_ack", o_dbus_ack, 1'b1);
    step(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;

`ifdef QERV_ARB_WATCHDOG_EN
    // real ack in the limit cycle wins
    i_dbus_adr = 32'h600; i_dbus_cyc = 1'b1;
    step(); repeat (4) step();
    i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFE0001;
    #2 chk1("wd_real_ack", o_dbus_ack, 1'b1);
    chk("wd_real_rdt", o_dbus_rdt, 32'hCAFE0001);
    step(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
    #2 chk1("wd_real_no_timeout", o_timeout, 1'b0);
    // memory never acks
    i_ibus_adr = 32'h700; i_ibus_cyc = 1'b1; i_wb_rdt = 32'hFFFFFFFF;
    step(); repeat (3) step();
    #2 chk1("wd_cyc_cycle3", o_wb_cyc, 1'b1);
    step(); #2;
    chk1("wd_ack", o_ibus_ack, 1'b1);
    chk("wd_rdt_zero", o_ibus_rdt, 32'h0);
    chk1("wd_cyc_dropped", o_wb_cyc, 1'b0);
    step(); i_ibus_cyc = 1'b0;
    #2 chk1("wd_timeout_set", o_timeout, 1'b1);
    // flag stays through a normal transaction, clears on reset
    i_dbus_cyc = 1'b1; step(); i_wb_ack = 1'b1;
    step(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
    #2 chk1("wd_timeout_sticky", o_timeout, 1'b1);
    i_rst = 1'b1; step(); i_rst = 1'b0;
    #2 chk1("wd_timeout_cleared", o_timeout, 1'b0);
`else
    // without the watchdog an unacked fetch holds the port indefinitely
    i_ibus_adr = 32'h800; i_ibus_cyc = 1'b1;
    step(); repeat (300) step();
    #2 chk1("nowd_cyc_held", o_wb_cyc, 1'b1);
    chk1("nowd_timeout", o_timeout, 1'b0);
    i_wb_ack = 1'b1; #1 chk1("nowd_late_ack", o_ibus_ack, 1'b1);
    step(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
`endif

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
